mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, data/address width.
REQ-002 SHALL have parameter NB_SIZE, default 2, access-size code width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max wait for i_mem_ack.
REQ-004 SHALL have port i_clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_enable_pipe  in  1  pipeline advance enable from debug unit.
REQ-007 SHALL have port i_mem_read  in  1  load in MEM stage.
REQ-008 SHALL have port i_mem_write  in  1  store in MEM stage.
REQ-009 SHALL have port i_mem_size  in  NB_SIZE  00 byte, 01 half, 10 word; 11 treated as word.
REQ-010 SHALL have port i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port i_addr  in  NB_DATA  byte address (ALU result).
REQ-012 SHALL have port i_write_data  in  NB_DATA  store data, right-aligned.
REQ-013 SHALL have port i_mem_ack  in  1  memory completion strobe.
REQ-014 SHALL have port i_mem_rdata  in  NB_DATA  memory read word, valid with i_mem_ack.
REQ-015 SHALL have port o_mem_req  out  1  request, held until ack or timeout.
REQ-016 SHALL have port o_mem_we  out  1  1 = write.
REQ-017 SHALL have port o_mem_addr  out  NB_DATA-2  word address i_addr[NB_DATA-1:2].
REQ-018 SHALL have port o_mem_be  out  4  byte-lane enables.
REQ-019 SHALL have port o_mem_wdata  out  NB_DATA  lane-replicated store data.
REQ-020 SHALL have port o_read_data  out  NB_DATA  extended load data to MEM/WB latch.
REQ-021 SHALL have port o_stall  out  1  freezes upstream latches and PC.
REQ-022 SHALL have port o_misaligned  out  1  combinational misaligned-access flag.
REQ-023 SHALL have port o_mem_error  out  1  sticky timeout flag.

Function
REQ-024 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-025 IDLE: when i_enable_pipe and (read or write) and aligned, SHALL assert o_mem_req combinationally, o_stall=1, go ACCESS.
REQ-026 ACCESS: SHALL hold o_mem_req, o_mem_we, address, be, wdata stable and o_stall=1 until i_mem_ack.
REQ-027 On i_mem_ack in ACCESS SHALL register extended load data into o_read_data and go DONE; o_stall stays 1 that cycle.
REQ-028 DONE: SHALL drive o_stall=0, o_mem_req=0 for exactly one cycle, then go IDLE (no re-issue of same instruction).
REQ-029 Ack latency SHALL be 0..TIMEOUT_CYCLES-1 cycles after entering ACCESS; total stall = ack latency + 2 cycles.
REQ-030 Wait counter SHALL clear on entering ACCESS; reaching TIMEOUT_CYCLES SHALL set o_mem_error, force o_read_data=0, go DONE.
REQ-031 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; SHALL assert o_misaligned, issue no request, no stall, o_read_data=0.
REQ-032 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],0}; word 4'b1111.
REQ-033 Write data: byte replicated x4, half replicated x2, word as-is.
REQ-034 Load: select lane by addr[1:0] (little-endian), sign/zero-extend per i_unsigned.
REQ-035 Read and write both asserted SHALL be executed as write; o_read_data=0.
REQ-036 i_enable_pipe low in IDLE SHALL start nothing; in ACCESS/DONE SHALL not abort the transaction.
REQ-037 i_mem_ack in IDLE or DONE SHALL be ignored.
REQ-038 o_read_data SHALL hold its value outside DONE update.

Reset
REQ-039 Asserting i_reset SHALL immediately force IDLE, counter 0, o_read_data=0, o_mem_error=0, o_mem_req=0, o_stall=0, even mid-ACCESS.
REQ-040 First request SHALL be accepted on the first rising edge after reset deassertion.

Structure
REQ-041 Size codes, FSM state encodings and default timeout SHALL live in shared parameters.vh.
REQ-042 Lane select/extension SHALL be a combinational sub-module load_extend.

Verification
REQ-043 Word load addr 0x10, ack after 3 cycles, rdata 0xDEADBEEF -> o_stall high 5 cycles, o_read_data=0xDEADBEEF.
REQ-044 Signed byte load addr 0x13, rdata 0x80FF_FF12 -> o_read_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-045 Half store addr 0x22, data 0x0000ABCD -> o_mem_be=1100, o_mem_wdata=0xABCDABCD, o_mem_we=1.
REQ-046 Word load addr 0x06 -> o_misaligned=1, o_mem_req=0, o_stall=0.
REQ-047 No ack for 16 cycles -> o_mem_error=1, o_read_data=0, stall released; reset mid-ACCESS -> o_mem_req=0 immediately.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access unit: size codes, FSM encodings,
// default ack timeout and the alignment rule.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int DEF_TIMEOUT = 16;

    // Size code 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lane[0];
            default:   return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Little-endian lane select and sign/zero extension of a memory read word.
module load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int NB_DATA = 32
)(
    input  logic [NB_DATA-1:0] i_rdata,
    input  logic [1:0]         i_size,
    input  logic [1:0]         i_lane,
    input  logic               i_unsigned,
    output logic [NB_DATA-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SIZE_BYTE: o_data = {{(NB_DATA-8){~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{(NB_DATA-16){~i_unsigned & w_half[15]}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one memory request per instruction, stalls
// the pipeline until ack or timeout, and returns extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_SIZE        = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable_pipe,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [NB_SIZE-1:0] i_mem_size,
    input  logic               i_unsigned,
    input  logic [NB_DATA-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic               i_mem_ack,
    input  logic [NB_DATA-1:0] i_mem_rdata,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_DATA-3:0] o_mem_addr,
    output logic [3:0]         o_mem_be,
    output logic [NB_DATA-1:0] o_mem_wdata,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_stall,
    output logic               o_misaligned,
    output logic               o_mem_error
);

    localparam int NB_CNT = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]         r_state;
    logic [NB_CNT-1:0]  r_cnt;
    logic               r_we;
    logic               r_unsigned;
    logic               r_error;
    logic [1:0]         r_size;
    logic [1:0]         r_lane;
    logic [NB_DATA-3:0] r_addr;
    logic [3:0]         r_be;
    logic [NB_DATA-1:0] r_wdata;
    logic [NB_DATA-1:0] r_read_data;

    logic [1:0]         w_size;
    logic               w_access;
    logic               w_misaligned;
    logic               w_start;
    logic               w_in_access;
    logic               w_busy;
    logic [3:0]         w_be;
    logic [NB_DATA-1:0] w_wdata;
    logic [NB_DATA-1:0] w_ext;

    assign w_size       = i_mem_size[1:0];
    assign w_access     = i_mem_read | i_mem_write;
    assign w_misaligned = is_misaligned(w_size, i_addr[1:0]);
    assign w_in_access  = (r_state == ST_ACCESS);
    assign w_start      = (r_state == ST_IDLE) & i_enable_pipe & w_access & ~w_misaligned;
    assign w_busy       = ~i_reset & (w_start | w_in_access);

    always_comb begin
        case (w_size)
            SIZE_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_write_data[7:0]}};
            end
            SIZE_HALF: begin
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_write_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_write_data;
            end
        endcase
    end

    // Issue cycle drives the bus straight from the inputs; ACCESS replays the captured copy.
    assign o_mem_req    = w_busy;
    assign o_stall      = w_busy;
    assign o_mem_we     = w_in_access ? r_we    : (w_start & i_mem_write);
    assign o_mem_addr   = w_in_access ? r_addr  : i_addr[NB_DATA-1:2];
    assign o_mem_be     = w_in_access ? r_be    : (w_start ? w_be : 4'b0000);
    assign o_mem_wdata  = w_in_access ? r_wdata : (w_start ? w_wdata : '0);
    assign o_misaligned = w_access & w_misaligned;
    assign o_read_data  = r_read_data;
    assign o_mem_error  = r_error;

    load_extend #(.NB_DATA(NB_DATA)) u_load_extend (
        .i_rdata    (i_mem_rdata),
        .i_size     (r_size),
        .i_lane     (r_lane),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_error     <= 1'b0;
            r_size      <= SIZE_WORD;
            r_lane      <= 2'b00;
            r_addr      <= '0;
            r_be        <= 4'b0000;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_ACCESS;
                        r_cnt      <= '0;
                        r_we       <= i_mem_write;
                        r_unsigned <= i_unsigned;
                        r_size     <= w_size;
                        r_lane     <= i_addr[1:0];
                        r_addr     <= i_addr[NB_DATA-1:2];
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                    end else if (i_enable_pipe & w_access & w_misaligned) begin
                        r_read_data <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (i_mem_ack) begin
                        r_state     <= ST_DONE;
                        r_read_data <= r_we ? '0 : w_ext;
                    end else if (r_cnt == NB_CNT'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= ST_DONE;
                        r_error     <= 1'b1;
                        r_read_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table for single accesses plus
// hand-written sequences for latency, timeout, reset and ignored-ack cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable_pipe;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_mem_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic [31:0] o_read_data;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_mem_error;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(.NB_DATA(32), .NB_SIZE(2), .TIMEOUT_CYCLES(16)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_enable_pipe (i_enable_pipe),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_mem_size    (i_mem_size),
        .i_unsigned    (i_unsigned),
        .i_addr        (i_addr),
        .i_write_data  (i_write_data),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_be      (o_mem_be),
        .o_mem_wdata   (o_mem_wdata),
        .o_read_data   (o_read_data),
        .o_stall       (o_stall),
        .o_misaligned  (o_misaligned),
        .o_mem_error   (o_mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata, rdata;
        logic        req, mis, we;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vec[17];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word load; ack arrives lat cycles after entering ACCESS. Returns in DONE (or after the bound).
    task automatic run_load(input logic [31:0] addr, input int lat, input logic [31:0] rdata,
                            input logic drop_en, output int nstall);
        i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_size = 2'b10; i_unsigned = 1'b0;
        i_addr = addr; i_enable_pipe = 1'b1;
        nstall = 0;
        for (int c = 0; c < 40; c++) begin
            i_mem_ack   = (c == lat + 1);
            i_mem_rdata = (c == lat + 1) ? rdata : 32'h0;
            if (c >= 1 && drop_en) i_enable_pipe = 1'b0;
            #1;
            if (!o_stall) break;
            nstall++;
            tick();
        end
        i_mem_ack = 1'b0; i_mem_read = 1'b0; i_enable_pipe = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ns;
        vec_t v;
        //        en    rd    wr    size   uns   addr          wdata         rdata         req   mis   we    be       exp_wd        chk   exp_rd
        vec[0]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0,        32'h80FFFF12, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFFFF80};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0,        32'h80FFFF12, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h00000080};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h00000012, 32'h0,        32'h80FFFF12, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF80FF};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h00000010, 32'h0,        32'h80FFFF12, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h0,        1'b1, 32'h0000FF12};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h00000011, 32'h0,        32'h80FFFF12, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h0,        1'b1, 32'hFFFFFFFF};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h00000014, 32'h0,        32'h12345678, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h12345678};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h00000018, 32'h0,        32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h12345678};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h00000002, 32'h0,        32'h7FFF1234, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h00007FFF};
        vec[10] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h00000013, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vec[11] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h00000022, 32'h0000ABCD, 32'h0,        1'b1, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0};
        vec[12] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h00000001, 32'h000000A5, 32'h0,        1'b1, 1'b0, 1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0};
        vec[13] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h00000008, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h00000004, 32'h0,        32'h5555AAAA, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h5555AAAA};
        vec[15] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000000C, 32'h11223344, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h11223344, 1'b1, 32'h0};
        vec[16] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h00000002, 32'h12345678, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};

        i_reset = 1'b1; i_enable_pipe = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_mem_size = 2'b10; i_unsigned = 1'b0; i_addr = '0; i_write_data = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        tick(); tick();
        chk1("rst_req", o_mem_req, 1'b0);
        chk1("rst_stall", o_stall, 1'b0);
        chk32("rst_rdata", o_read_data, 32'h0);
        chk1("rst_err", o_mem_error, 1'b0);
        i_reset = 1'b0;

        for (int k = 0; k < 17; k++) begin
            v = vec[k];
            i_enable_pipe = v.en; i_mem_read = v.rd; i_mem_write = v.wr; i_mem_size = v.size;
            i_unsigned = v.uns; i_addr = v.addr; i_write_data = v.wdata; i_mem_ack = 1'b0;
            #1;
            chk1($sformatf("v%0d_req", k), o_mem_req, v.req);
            chk1($sformatf("v%0d_stall", k), o_stall, v.req);
            chk1($sformatf("v%0d_mis", k), o_misaligned, v.mis);
            chk1($sformatf("v%0d_we", k), o_mem_we, v.we);
            chk32($sformatf("v%0d_be", k), {28'h0, o_mem_be}, {28'h0, v.be});
            chk32($sformatf("v%0d_wdata", k), o_mem_wdata, v.exp_wd);
            if (v.req) begin
                chk32($sformatf("v%0d_addr", k), {2'b00, o_mem_addr}, v.addr >> 2);
                tick();
                i_mem_read = 1'b0; i_mem_write = 1'b0; i_addr = '0; i_write_data = '0;
                #1;
                chk1($sformatf("v%0d_hold_req", k), o_mem_req, 1'b1);
                chk1($sformatf("v%0d_hold_we", k), o_mem_we, v.we);
                chk32($sformatf("v%0d_hold_be", k), {28'h0, o_mem_be}, {28'h0, v.be});
                chk32($sformatf("v%0d_hold_wdata", k), o_mem_wdata, v.exp_wd);
                chk32($sformatf("v%0d_hold_addr", k), {2'b00, o_mem_addr}, v.addr >> 2);
                i_mem_ack = 1'b1; i_mem_rdata = v.rdata;
                tick();
                i_mem_ack = 1'b0;
                #1;
                chk1($sformatf("v%0d_done_stall", k), o_stall, 1'b0);
                chk1($sformatf("v%0d_done_req", k), o_mem_req, 1'b0);
                if (v.chk_rd) chk32($sformatf("v%0d_rdata", k), o_read_data, v.exp_rd);
                tick();
            end else begin
                tick();
                i_mem_read = 1'b0; i_mem_write = 1'b0;
                #1;
                if (v.chk_rd) chk32($sformatf("v%0d_rdata", k), o_read_data, v.exp_rd);
            end
        end

        // Word load, ack three cycles into ACCESS: five stall cycles.
        run_load(32'h10, 3, 32'hDEADBEEF, 1'b0, ns);
        chk32("lat3_stall_cycles", ns, 5);
        chk32("lat3_rdata", o_read_data, 32'hDEADBEEF);
        chk1("lat3_done_req", o_mem_req, 1'b0);
        // Ack during DONE and then IDLE must not disturb the result.
        i_mem_ack = 1'b1; i_mem_rdata = 32'h12121212;
        tick();
        chk32("ack_done_ignored", o_read_data, 32'hDEADBEEF);
        tick();
        chk32("ack_idle_ignored", o_read_data, 32'hDEADBEEF);
        chk1("ack_idle_stall", o_stall, 1'b0);
        i_mem_ack = 1'b0;

        run_load(32'h30, 2, 32'h600DF00D, 1'b1, ns);
        chk32("en_drop_stall_cycles", ns, 4);
        chk32("en_drop_rdata", o_read_data, 32'h600DF00D);
        tick();

        run_load(32'h34, 15, 32'h0BADC0DE, 1'b0, ns);
        chk32("maxlat_stall_cycles", ns, 17);
        chk32("maxlat_rdata", o_read_data, 32'h0BADC0DE);
        chk1("maxlat_no_err", o_mem_error, 1'b0);
        tick();

        run_load(32'h38, 99, 32'h0, 1'b0, ns);
        chk32("timeout_stall_cycles", ns, 17);
        chk1("timeout_err", o_mem_error, 1'b1);
        chk32("timeout_rdata", o_read_data, 32'h0);
        tick();

        run_load(32'h3C, 1, 32'h13572468, 1'b0, ns);
        chk32("post_to_stall_cycles", ns, 3);
        chk32("post_to_rdata", o_read_data, 32'h13572468);
        chk1("err_sticky", o_mem_error, 1'b1);
        tick();

        // Reset in the middle of ACCESS releases everything at once.
        i_mem_read = 1'b1; i_mem_size = 2'b10; i_addr = 32'h40; i_enable_pipe = 1'b1;
        tick(); tick();
        chk1("mid_access_req", o_mem_req, 1'b1);
        i_reset = 1'b1;
        #1;
        chk1("midrst_req", o_mem_req, 1'b0);
        chk1("midrst_stall", o_stall, 1'b0);
        chk32("midrst_rdata", o_read_data, 32'h0);
        chk1("midrst_err", o_mem_error, 1'b0);
        tick();
        i_mem_read = 1'b0;
        i_reset = 1'b0;

        run_load(32'h44, 0, 32'h2468ACE0, 1'b0, ns);
        chk32("post_rst_stall_cycles", ns, 2);
        chk32("post_rst_rdata", o_read_data, 32'h2468ACE0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
